// File: rtl/unpack_pkg.sv
// Shared definitions for the unpacker front end.
//   WORD_W      : width of one word fed to the unpacker
//   SYM_W       : width of one output symbol produced by the unpacker
//   word_t      : one unpacker input word
//   arb_state_t : packet lock state of the source arbiter
package unpack_pkg;

  localparam int WORD_W = 32;
  localparam int SYM_W  = 7;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/unpack_rr_pick.sv
// Rotating-priority picker. Starting at ptr+1 and wrapping around, returns
// the first index whose request bit is set.
//   req  : request vector, one bit per source
//   ptr  : index of the last winner (lowest priority this round)
//   pick : winning index (0 when no request)
//   any  : at least one request is present
module unpack_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] pick,
  output logic            any
);

  int              cand;
  logic [ID_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    cand = 0;
    idx  = '0;
    // Offsets 1..N visit every index once, ending on ptr itself.
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      idx  = ID_W'(cand);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/unpack_src_arbiter.sv
// Packet-level round-robin arbiter sharing one unpacker between NUM_SRC word
// sources. A source is granted on its first word and keeps the lock until its
// eop word is accepted. Words leave through a single registered output stage.
// A watchdog releases a lock whose source has gone quiet for TIMEOUT cycles.
//
// Handshake semantics (both sides): a word moves on a rising clk edge when
// valid and ready are both high in the preceding cycle. Valid never waits on
// ready. While dn_valid is high and dn_ready is low, dn_* hold stable.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   src_valid/src_data/src_sop/src_eop : per-source word inputs,
//                   source i data at src_data[i*WORD_W +: WORD_W]
//   src_ready     : per-source accept, at most one bit set
//   dn_valid/dn_data/dn_sop/dn_eop : registered word to the unpacker
//   dn_ready      : unpacker ready
//   dn_src_id     : source index of the word on dn_*
//   err_timeout   : one-cycle pulse when the watchdog releases a lock
//   err_src       : source released by the last watchdog event
module unpack_src_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WORD_W  = unpack_pkg::WORD_W,
  parameter int TIMEOUT = 64,
  localparam int ID_W   = $clog2(NUM_SRC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*WORD_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_sop,
  input  logic [NUM_SRC-1:0]          src_eop,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        dn_valid,
  output logic [WORD_W-1:0]           dn_data,
  output logic                        dn_sop,
  output logic                        dn_eop,
  input  logic                        dn_ready,
  output logic [ID_W-1:0]             dn_src_id,
  output logic                        err_timeout,
  output logic [ID_W-1:0]             err_src
);

  import unpack_pkg::*;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t      state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] xfer_idx;
  logic            any_req;
  logic            out_free;
  logic            src_xfer;
  logic            xfer_eop;
  logic            wd_expire;
  logic [WD_W-1:0] wd_cnt;

  unpack_rr_pick #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_pick (
    .req  (src_valid),
    .ptr  (rr_ptr),
    .pick (pick),
    .any  (any_req)
  );

  assign out_free = ~dn_valid | dn_ready;
  assign xfer_idx = (state == IDLE) ? pick : gnt;
  assign src_xfer = |(src_valid & src_ready);
  assign xfer_eop = src_eop[xfer_idx];

  // Expiry needs the granted source idle this cycle, so an eop transfer in
  // the same cycle always wins over the watchdog.
  assign wd_expire = (TIMEOUT != 0) && (state == LOCKED) &&
                     !src_valid[gnt] && (wd_cnt == WD_LAST);

  always_comb begin
    src_ready = '0;
    state_nxt = state;
    case (state)
      IDLE: begin
        // rst gating keeps src_ready low throughout reset.
        if (!rst && any_req && out_free) begin
          src_ready[pick] = 1'b1;
          if (!src_eop[pick]) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        src_ready[gnt] = out_free & ~rst;
        if (src_xfer && xfer_eop) state_nxt = IDLE;
        else if (wd_expire)       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= ID_W'(NUM_SRC - 1);
      gnt         <= '0;
      wd_cnt      <= '0;
      dn_valid    <= 1'b0;
      dn_data     <= '0;
      dn_sop      <= 1'b0;
      dn_eop      <= 1'b0;
      dn_src_id   <= '0;
      err_timeout <= 1'b0;
      err_src     <= '0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && src_xfer) begin
        rr_ptr <= pick;
        gnt    <= pick;
      end

      // Restart on every accepted word (which also covers entering LOCKED);
      // only idle cycles of the granted source advance the count, so
      // downstream backpressure with a waiting word never trips it.
      if (state_nxt != LOCKED || src_xfer) wd_cnt <= '0;
      else if (!src_valid[gnt])           wd_cnt <= wd_cnt + 1'b1;

      if (src_xfer) begin
        dn_valid  <= 1'b1;
        dn_data   <= src_data[xfer_idx*WORD_W +: WORD_W];
        // The first word of a granted packet is always marked sop.
        dn_sop    <= (state == IDLE) | src_sop[xfer_idx];
        dn_eop    <= xfer_eop;
        dn_src_id <= xfer_idx;
      end else if (dn_ready) begin
        dn_valid  <= 1'b0;
      end

      err_timeout <= wd_expire;
      if (wd_expire) err_src <= gnt;
    end
  end

endmodule
